tpg_pattern_sched: RTL and testbench

- Frame-synchronous scheduler that sequences the display mode of four test-pattern-generator channels feeding the four-channel splicer.
- Replaces each TPG's free-running internal mode counter with an explicit 4-bit mode per channel.
- Mode changes apply only on the frame-sync leading edge, so no frame ever shows a mid-frame pattern switch.
- Supports automatic rotation every N frames, single-step, and manual mode load via valid/ready handshake.

---
 rtl/tpg_pkg.sv | 47 ++++
 rtl/tpg_pattern_sched_mode_map.sv | 17 +
 rtl/tpg_pattern_sched.sv | 165 ++++++++++++++++
 tb/tb_tpg_pattern_sched.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tpg_pkg.sv
// Shared types and constants for the test-pattern-generator channels.
// Holds the mode map used by the scheduler and its reset value.
package tpg_pkg;

  localparam int TPG_MODE_W = 4;

  typedef enum logic [1:0] {
    S_AUTO     = 2'd0,
    S_MAN_IDLE = 2'd1,
    S_MAN_PEND = 2'd2
  } sched_state_e;

  typedef enum logic [TPG_MODE_W-1:0] {
    GRID    = 4'd0,
    VGRAD   = 4'd1,
    WHITE   = 4'd2,
    CBAR    = 4'd3,
    BLACK   = 4'd4,
    HGRAD   = 4'd5,
    RED     = 4'd6,
    GREEN   = 4'd7,
    BLUE    = 4'd8,
    CHECKER = 4'd9,
    RAMP    = 4'd10,
    CBAR2   = 4'd11
  } tpg_mode_e;

  // b + k*off stays below 4*nm, so three conditional subtracts suffice
  function automatic logic [15:0] tpg_map(
    input logic [TPG_MODE_W-1:0] b,
    input int                    nm,
    input int                    off
  );
    logic [15:0] r;
    logic [7:0]  s;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      s = {4'd0, b} + 8'(k * off);
      for (int j = 0; j < 3; j++) begin
        if (s >= 8'(nm)) s = s - 8'(nm);
      end
      r[k*4 +: 4] = s[3:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/tpg_pattern_sched_mode_map.sv
// Base mode to four channel modes, channel k offset by k*CH_OFFSET.
// Purely combinational; the parent registers the result.
module tpg_mode_map
  import tpg_pkg::*;
#(
  parameter int NUM_MODES = 12,
  parameter int CH_OFFSET = 1
) (
  input  logic [TPG_MODE_W-1:0] base_i,
  output logic [15:0]           ch_mode_o
);

  always_comb begin
    ch_mode_o = tpg_map(base_i, NUM_MODES, CH_OFFSET);
  end

endmodule

// File: rtl/tpg_pattern_sched.sv
// Frame-synchronous mode scheduler for four TPG channels.
// Modes only change on the frame-sync leading edge.
module tpg_pattern_sched
  import tpg_pkg::*;
#(
  parameter int NUM_MODES = 12,
  parameter int CH_OFFSET = 1,
  parameter int VS_POL    = 1,
  parameter int HOLD_W    = 8
) (
  input  logic              I_tpg_clk,
  input  logic              I_tpg_rstn,
  input  logic              I_tpg_vs,
  input  logic              I_auto_en,
  input  logic [HOLD_W-1:0] I_hold_frames,
  input  logic              I_step,
  input  logic              I_man_valid,
  input  logic [3:0]        I_man_mode,
  output logic              O_man_ready,
  output logic [15:0]       O_ch_mode,
  output logic              O_mode_upd,
  output logic              O_err
);

  localparam logic [15:0] RST_MODE =
    tpg_map(4'd0, NUM_MODES, CH_OFFSET);
  localparam logic [3:0] LAST = 4'(NUM_MODES - 1);
  localparam logic VS_LVL = (VS_POL != 0);

  sched_state_e      state_q, state_d;
  logic [3:0]        base_q, base_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              step_q, step_d;
  logic [3:0]        pend_q, pend_d;
  logic [15:0]       ch_q, ch_d;
  logic              upd_q, upd_d;
  logic              err_q, err_d;
  logic              vs_q;

  logic              vs_act;
  logic              vs_rise;
  logic              hs;
  logic              man_ok;
  logic [HOLD_W-1:0] hold_lim;
  logic [3:0]        base_inc;

  assign vs_act  = (I_tpg_vs == VS_LVL);
  assign vs_rise = vs_act & ~vs_q;
  assign hs      = I_man_valid & O_man_ready;
  assign man_ok  = {1'b0, I_man_mode} < 5'(NUM_MODES);

  assign hold_lim = (I_hold_frames == '0) ? '0
                  : I_hold_frames - HOLD_W'(1);
  assign base_inc = (base_q == LAST) ? 4'd0
                  : base_q + 4'd1;

  always_ff @(posedge I_tpg_clk or negedge I_tpg_rstn) begin
    if (!I_tpg_rstn) state_q <= S_AUTO;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_AUTO: begin
        if (!I_auto_en) state_d = S_MAN_IDLE;
      end
      S_MAN_IDLE: begin
        if (I_auto_en)        state_d = S_AUTO;
        else if (hs && man_ok) state_d = S_MAN_PEND;
      end
      S_MAN_PEND: begin
        if (I_auto_en)    state_d = S_AUTO;
        else if (vs_rise) state_d = S_MAN_IDLE;
      end
      default: state_d = S_AUTO;
    endcase
  end

  always_comb begin
    O_man_ready = (state_q == S_MAN_IDLE);
    O_ch_mode   = ch_q;
    O_mode_upd  = upd_q;
    O_err       = err_q;
  end

  always_comb begin
    base_d = base_q;
    hold_d = hold_q;
    step_d = step_q;
    pend_d = pend_q;
    unique case (state_q)
      S_AUTO: begin
        step_d = 1'b0;
        if (I_auto_en && vs_rise) begin
          if (hold_q >= hold_lim) begin
            base_d = base_inc;
            hold_d = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      S_MAN_IDLE: begin
        if (I_auto_en) begin
          hold_d = '0;
          step_d = 1'b0;
          pend_d = '0;
        end else begin
          // a step landing on vs_rise is kept for the next frame
          if (vs_rise && step_q) base_d = base_inc;
          step_d = (step_q & ~vs_rise) | I_step;
          if (hs && man_ok) pend_d = I_man_mode;
        end
      end
      S_MAN_PEND: begin
        if (I_auto_en) begin
          hold_d = '0;
          step_d = 1'b0;
          pend_d = '0;
        end else if (vs_rise) begin
          base_d = pend_q;
          step_d = 1'b0;
        end else begin
          step_d = step_q | I_step;
        end
      end
      default: ;
    endcase
  end

  tpg_mode_map #(
    .NUM_MODES (NUM_MODES),
    .CH_OFFSET (CH_OFFSET)
  ) u_map (
    .base_i    (base_d),
    .ch_mode_o (ch_d)
  );

  assign upd_d = (ch_d != ch_q);
  assign err_d = hs & ~man_ok;

  always_ff @(posedge I_tpg_clk or negedge I_tpg_rstn) begin
    if (!I_tpg_rstn) begin
      base_q <= '0;
      hold_q <= '0;
      step_q <= 1'b0;
      pend_q <= '0;
      ch_q   <= RST_MODE;
      upd_q  <= 1'b0;
      err_q  <= 1'b0;
      vs_q   <= 1'b0;
    end else begin
      base_q <= base_d;
      hold_q <= hold_d;
      step_q <= step_d;
      pend_q <= pend_d;
      ch_q   <= ch_d;
      upd_q  <= upd_d;
      err_q  <= err_d;
      vs_q   <= vs_act;
    end
  end

endmodule

// File: tb/tb_tpg_pattern_sched.sv
// Directed bench for tpg_pattern_sched, both sync polarities.
// Expected channel modes are queued and popped on each update pulse.
module tb_tpg_pattern_sched;

  localparam int NM = 12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vs;
  logic       vs_n;
  logic       auto_en;
  logic [7:0] hold;
  logic       step;
  logic       mvalid;
  logic [3:0] mmode;

  logic        rdy_p, upd_p, err_p;
  logic        rdy_n, upd_n, err_n;
  logic [15:0] ch_p, ch_n;

  logic [15:0] q_p[$];
  logic [15:0] q_n[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cur_b = 0;

  assign vs_n = ~vs;

  always #5 clk = ~clk;

  tpg_pattern_sched #(.VS_POL(1)) dut_p (
    .I_tpg_clk     (clk),
    .I_tpg_rstn    (rst_n),
    .I_tpg_vs      (vs),
    .I_auto_en     (auto_en),
    .I_hold_frames (hold),
    .I_step        (step),
    .I_man_valid   (mvalid),
    .I_man_mode    (mmode),
    .O_man_ready   (rdy_p),
    .O_ch_mode     (ch_p),
    .O_mode_upd    (upd_p),
    .O_err         (err_p)
  );

  tpg_pattern_sched #(.VS_POL(0)) dut_n (
    .I_tpg_clk     (clk),
    .I_tpg_rstn    (rst_n),
    .I_tpg_vs      (vs_n),
    .I_auto_en     (auto_en),
    .I_hold_frames (hold),
    .I_step        (step),
    .I_man_valid   (mvalid),
    .I_man_mode    (mmode),
    .O_man_ready   (rdy_n),
    .O_ch_mode     (ch_n),
    .O_mode_upd    (upd_n),
    .O_err         (err_n)
  );

  function automatic logic [15:0] f(input int b);
    logic [15:0] r;
    for (int k = 0; k < 4; k++) r[k*4 +: 4] = 4'((b + k) % NM);
    return r;
  endfunction

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic both(input string tag,
                      input logic [15:0] op,
                      input logic [15:0] on,
                      input logic [15:0] exp);
    chk({tag, "_p"}, op, exp);
    chk({tag, "_n"}, on, exp);
  endtask

  // one frame; vs_rise is seen at the first edge after vs goes active
  task automatic frame_exp(input int nb, input int act = 3);
    logic chg;
    chg = (f(nb) != f(cur_b));
    if (chg) begin
      q_p.push_back(f(nb));
      q_n.push_back(f(nb));
    end
    vs = 1'b1;
    tick();
    both("frame_mode", ch_p, ch_n, f(nb));
    both("frame_upd", 16'(upd_p), 16'(upd_n), 16'(chg));
    tick(act - 1);
    vs = 1'b0;
    tick(5);
    cur_b = nb;
  endtask

  task automatic handshake(input logic [3:0] m);
    mvalid = 1'b1;
    mmode  = m;
    tick();
    mvalid = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (upd_p) begin
        if (q_p.size() == 0) chk("upd_unexp_p", 16'(upd_p), 16'd0);
        else chk("sb_mode_p", ch_p, q_p.pop_front());
      end
      if (upd_n) begin
        if (q_n.size() == 0) chk("upd_unexp_n", 16'(upd_n), 16'd0);
        else chk("sb_mode_n", ch_n, q_n.pop_front());
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    vs      = 1'b0;
    auto_en = 1'b1;
    hold    = 8'd2;
    step    = 1'b0;
    mvalid  = 1'b0;
    mmode   = 4'd0;
    tick(2);
    both("rst_mode", ch_p, ch_n, 16'h3210);
    both("rst_rdy", 16'(rdy_p), 16'(rdy_n), 16'd0);
    both("rst_upd", 16'(upd_p), 16'(upd_n), 16'd0);
    both("rst_err", 16'(err_p), 16'(err_n), 16'd0);
    rst_n = 1'b1;
    tick(2);

    for (int i = 1; i <= 6; i++)
      frame_exp((i % 2 == 0) ? (cur_b + 1) % NM : cur_b);
    both("auto_hold2", ch_p, ch_n, 16'h6543);

    hold = 8'd0;
    for (int i = 0; i < 9; i++) frame_exp((cur_b + 1) % NM);
    both("auto_wrap", ch_p, ch_n, 16'h3210);

    auto_en = 1'b0;
    tick();
    both("man_rdy", 16'(rdy_p), 16'(rdy_n), 16'd1);
    tick(2);
    handshake(4'd7);
    both("pend_rdy", 16'(rdy_p), 16'(rdy_n), 16'd0);
    tick(2);
    frame_exp(7);
    both("load7", ch_p, ch_n, 16'hA987);
    both("rdy_back", 16'(rdy_p), 16'(rdy_n), 16'd1);

    handshake(4'd13);
    both("err_pulse", 16'(err_p), 16'(err_n), 16'd1);
    both("err_rdy", 16'(rdy_p), 16'(rdy_n), 16'd1);
    tick();
    both("err_clr", 16'(err_p), 16'(err_n), 16'd0);
    both("err_mode", ch_p, ch_n, 16'hA987);

    pulse_step();
    frame_exp(8);

    pulse_step();
    pulse_step();
    pulse_step();
    handshake(4'd5);
    tick(2);
    frame_exp(5);
    both("load_wins", ch_p, ch_n, 16'h8765);
    frame_exp(5);

    pulse_step();
    pulse_step();
    frame_exp(6);

    handshake(4'd6);
    frame_exp(6);
    both("same_rdy", 16'(rdy_p), 16'(rdy_n), 16'd1);

    handshake(4'd11);
    frame_exp(11);
    pulse_step();
    frame_exp(0);
    both("step_wrap", ch_p, ch_n, 16'h3210);
    pulse_step();
    frame_exp(1);

    handshake(4'd2);
    tick(2);
    rst_n   = 1'b0;
    auto_en = 1'b1;
    hold    = 8'd3;
    #1;
    both("arst_mode", ch_p, ch_n, 16'h3210);
    both("arst_rdy", 16'(rdy_p), 16'(rdy_n), 16'd0);
    cur_b = 0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    frame_exp(0);
    frame_exp(0, 20);
    frame_exp(1);
    both("post_rst", ch_p, ch_n, 16'h4321);

    tick(3);
    chk("sb_empty_p", 16'(q_p.size()), 16'd0);
    chk("sb_empty_n", 16'(q_n.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
